cic_interp_integ: RTL and testbench
===================================

CIC_INTERP_INTEG -- requirements
Module: cic_interp_integ

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32: sample and integrator width, two's complement.
REQ-002 The block SHALL have parameter RATIO, default 64: interpolation ratio, legal range 2..1024.
REQ-003 The block SHALL have parameter STAGES, default 3: number of integrator stages, legal range 1..6.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ena, input, 1 bit: high-rate sample tick; one integrator update per cycle with ena=1.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous flush of phase, holding register, integrators and the underrun flag.
REQ-008 The block SHALL have port in_data, input, BITWIDTH bits: low-rate sample from the last comb stage.
REQ-009 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-011 The block SHALL have port out_data, output, BITWIDTH bits: last integrator value, fed to the sigma-delta modulator.
REQ-012 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new out_data.
REQ-013 The block SHALL have port underrun, output, 1 bit: sticky flag, set when a sample was due but the holding register was empty.

Function
REQ-014 The block SHALL keep a phase counter 0..RATIO-1 that advances on each ena cycle and wraps from RATIO-1 to 0.
REQ-015 The block SHALL keep a one-entry holding register; a transfer occurs when in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 when the holding register is empty, or when (ena=1 and phase=0), which is the same-cycle consume-and-refill case; it SHALL be 0 during reset and during clr.
REQ-017 The zero-stuffed input x SHALL be the holding register value on an ena cycle with phase=0 and the register full, and 0 on every other ena cycle.
REQ-018 When ena=1, phase=0 and the register is full, the block SHALL empty the register, unless a new transfer occurs in the same cycle, in which case it SHALL load the new sample.
REQ-019 When ena=1, phase=0 and the register is empty, the block SHALL use x=0 and set underrun=1.
REQ-020 On each ena cycle the integrators SHALL update as int[0] <= int[0] + x and int[k] <= int[k] + int[k-1] (old value) for k≥1, with modulo 2^BITWIDTH wrap and no saturation.
REQ-021 out_data SHALL equal int[STAGES-1]; out_valid SHALL be 1 in the cycle after each ena cycle and 0 otherwise.
REQ-022 Latency: a sample consumed on ena tick t SHALL first affect out_data after tick t+STAGES-1, that is, in the out_valid cycle of that tick.
REQ-023 With ena=0, the phase, integrators and out_data SHALL hold; transfers into an empty holding register SHALL still occur.
REQ-024 clr SHALL take priority over ena and over transfers.
REQ-025 clr SHALL zero the phase and integrators, empty the holding register and clear underrun; out_valid SHALL be 0 in the following cycle.

Reset
REQ-026 rst=0 SHALL asynchronously force the following to 0: phase, all integrators, holding register (data and full bit), out_data, out_valid and underrun.
REQ-027 After rst=0, the first ena tick SHALL be phase 0.
REQ-028 A reset mid-period SHALL discard any held sample and any partial interpolation.

Structure
REQ-029 Package cic_pkg SHALL hold the default BITWIDTH, RATIO and STAGES constants.
REQ-030 Package cic_pkg SHALL hold the phase-width function $clog2(RATIO).
REQ-031 Package cic_pkg SHALL hold a parameterised sample type, which is shared with the comb stage.
REQ-032 The integrator SHALL be one sub-module, cic_integ (clk, rst, ena, clr, in, out), instantiated STAGES times in a generate loop.

Verification
REQ-033 Impulse test: RATIO=4, STAGES=1, one sample 5 then zeros -> out_data=5 from the first out_valid onward and held.
REQ-034 Ramp test: RATIO=4, STAGES=2, sample 1 then zeros -> out_data sequence 0,1,2,3,4,... on successive out_valid pulses.
REQ-035 Wrap test: BITWIDTH=8, STAGES=1, RATIO=2, in_data=100 each period -> out_data 100, 100, -56, -56 (0xC8), 44, ...
REQ-036 Underrun test: in_valid=0 at a phase-0 ena tick -> x=0, integrators unchanged by input, and underrun=1 until clr pulse.
REQ-037 Backpressure test: holding register full with in_valid held at 1 -> in_ready=0 until the phase-0 ena tick, where the same-cycle refill is accepted.
REQ-038 Reset test: rst=0 asserted mid-period (phase=2) -> all outputs 0 immediately; after release the first ena tick is phase 0 and no stale sample appears.

Source files
------------

// File: rtl/cic_pkg.sv
// ---------------------------------------------------------------------------
// cic_pkg
// Shared constants and helpers for the CIC interpolator integrator section.
//   DEF_BITWIDTH / DEF_RATIO / DEF_STAGES : default sample width, ratio, stages
//   phase_width()                         : width of the 0..RATIO-1 phase counter
//   sample_t                              : sample type shared with the comb stage
// ---------------------------------------------------------------------------
package cic_pkg;

   localparam int DEF_BITWIDTH = 32;
   localparam int DEF_RATIO    = 64;
   localparam int DEF_STAGES   = 3;

   // Bits needed to count phases 0..ratio-1.
   function automatic int phase_width(input int ratio);
      return $clog2(ratio);
   endfunction

   // Two's-complement sample word exchanged between comb and integrator sections
   // at the default width; width-parameterised instances use the same layout.
   typedef logic signed [DEF_BITWIDTH-1:0] sample_t;

endpackage

// File: rtl/cic_integ.sv
// ---------------------------------------------------------------------------
// cic_integ
// One CIC integrator stage: out <= out + in on every ena cycle, wrapping
// modulo 2^BITWIDTH (no saturation).
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, clears the accumulator
//   ena  : high-rate tick, one accumulate per cycle with ena=1
//   clr  : synchronous clear, takes priority over ena
//   in   : stage input (zero-stuffed sample or previous stage output)
//   out  : accumulator value
// ---------------------------------------------------------------------------
module cic_integ
   import cic_pkg::*;
#(
   parameter int BITWIDTH = DEF_BITWIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic                clr,
   input  logic [BITWIDTH-1:0] in,
   output logic [BITWIDTH-1:0] out
);

   logic [BITWIDTH-1:0] acc;

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its neighbour's old value on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (ena) begin
         acc <= acc + in;
      end
   end

   assign out = acc;

endmodule

// File: rtl/cic_interp_integ.sv
// ---------------------------------------------------------------------------
// cic_interp_integ
// Integrator section of a CIC interpolator. Accepts low-rate samples through a
// one-entry holding register, zero-stuffs them by RATIO and runs STAGES
// cascaded integrators at the high (ena) rate.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   ena       : high-rate sample tick
//   clr       : synchronous flush of phase, holding register, integrators, underrun
//   in_data   : low-rate sample from the last comb stage
//   in_valid  : in_data is valid
//   in_ready  : in_data is accepted this cycle
//   out_data  : last integrator value
//   out_valid : one-cycle pulse after every ena cycle
//   underrun  : sticky, a sample was due at phase 0 but the register was empty
// ---------------------------------------------------------------------------
module cic_interp_integ
   import cic_pkg::*;
#(
   parameter int BITWIDTH = DEF_BITWIDTH,
   parameter int RATIO    = DEF_RATIO,
   parameter int STAGES   = DEF_STAGES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic                clr,
   input  logic [BITWIDTH-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [BITWIDTH-1:0] out_data,
   output logic                out_valid,
   output logic                underrun
);

   localparam int PW = phase_width(RATIO);

   logic [PW-1:0]       phase;
   logic                full;
   logic [BITWIDTH-1:0] hold;
   logic                tick0;     // ena cycle at phase 0: a sample is due
   logic                transfer;
   logic                consume;
   logic [BITWIDTH-1:0] x;         // zero-stuffed integrator input

   logic [BITWIDTH-1:0] stage_in  [STAGES];
   logic [BITWIDTH-1:0] stage_out [STAGES];

   assign tick0    = ena && (phase == '0);
   // A full register can still take a sample in the cycle it is consumed.
   // Gated by rst so nothing is accepted while the block is held in reset.
   assign in_ready = rst && !clr && (!full || tick0);
   assign transfer = in_valid && in_ready;
   assign consume  = tick0 && full;
   assign x        = consume ? hold : '0;

   // Phase counter, wraps RATIO-1 -> 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (ena) begin
         phase <= (phase == PW'(RATIO - 1)) ? '0 : phase + PW'(1);
      end
   end

   // Holding register; a same-cycle refill wins over the consume.
   // NOTE: the data word is reset along with the full bit so a reset or clr
   // never leaves a stale sample behind, even though full alone gates its use.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= 1'b0;
         hold <= '0;
      end else if (clr) begin
         full <= 1'b0;
         hold <= '0;
      end else if (transfer) begin
         full <= 1'b1;
         hold <= in_data;
      end else if (consume) begin
         full <= 1'b0;
      end
   end

   // Sticky underrun and the out_valid pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         underrun  <= 1'b0;
         out_valid <= 1'b0;
      end else if (clr) begin
         underrun  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (tick0 && !full) begin
            underrun <= 1'b1;
         end
         out_valid <= ena;
      end
   end

   // Integrator cascade: stage k adds the registered output of stage k-1.
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign stage_in[g] = x;
      end else begin : g_rest
         assign stage_in[g] = stage_out[g-1];
      end

      cic_integ #(
         .BITWIDTH(BITWIDTH)
      ) u_integ (
         .clk (clk),
         .rst (rst),
         .ena (ena),
         .clr (clr),
         .in  (stage_in[g]),
         .out (stage_out[g])
      );
   end

   assign out_data = stage_out[STAGES-1];

endmodule

// File: tb/tb_cic_interp_integ.sv
// ---------------------------------------------------------------------------
// tb_cic_interp_integ
// Three instances share clk/rst/clr:
//   0 (a): BITWIDTH=32, RATIO=4, STAGES=1  -- impulse, underrun, backpressure
//   1 (b): BITWIDTH=32, RATIO=4, STAGES=2  -- ramp, mid-period reset
//   2 (c): BITWIDTH=8,  RATIO=2, STAGES=1  -- wrap-around
// Expected out_data values are queued when an ena tick is driven and popped
// when the instance raises out_valid.
// ---------------------------------------------------------------------------
module tb_cic_interp_integ;

   typedef struct {
      int          dut;
      bit          valid;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        ena       [3];
   logic        in_valid  [3];
   logic [31:0] in_data   [3];
   logic        in_ready  [3];
   logic        out_valid [3];
   logic        underrun  [3];
   logic [31:0] out_data_a;
   logic [31:0] out_data_b;
   logic [7:0]  out_data_c;

   logic [31:0] q_a [$];
   logic [31:0] q_b [$];
   logic [31:0] q_c [$];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cic_interp_integ #(.BITWIDTH(32), .RATIO(4), .STAGES(1)) u_a (
      .clk(clk), .rst(rst), .ena(ena[0]), .clr(clr),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .out_data(out_data_a), .out_valid(out_valid[0]), .underrun(underrun[0])
   );

   cic_interp_integ #(.BITWIDTH(32), .RATIO(4), .STAGES(2)) u_b (
      .clk(clk), .rst(rst), .ena(ena[1]), .clr(clr),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .out_data(out_data_b), .out_valid(out_valid[1]), .underrun(underrun[1])
   );

   cic_interp_integ #(.BITWIDTH(8), .RATIO(2), .STAGES(1)) u_c (
      .clk(clk), .rst(rst), .ena(ena[2]), .clr(clr),
      .in_data(in_data[2][7:0]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .out_data(out_data_c), .out_valid(out_valid[2]), .underrun(underrun[2])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ena[i]      = 1'b0;
         in_valid[i] = 1'b0;
         in_data[i]  = '0;
      end
   endtask

   task automatic push_exp(input int d, input logic [31:0] e);
      case (d)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   // One cycle offering a sample (ena=0), then one ena tick with in_valid=0.
   task automatic run_vec(input int d, input bit v, input logic [31:0] data, input logic [31:0] exp);
      in_valid[d] = v;
      in_data[d]  = data;
      ena[d]      = 1'b0;
      step();
      in_valid[d] = 1'b0;
      ena[d]      = 1'b1;
      push_exp(d, exp);
      step();
      ena[d]      = 1'b0;
   endtask

   // clr with samples offered everywhere: nothing may be accepted.
   task automatic clr_pulse();
      clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b1;
         in_data[i]  = 32'h5A;
      end
      #1;
      for (int i = 0; i < 3; i++) check($sformatf("clr_in_ready%0d", i), {31'b0, in_ready[i]}, 32'd0);
      step();
      idle();
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("clr_out_valid%0d", i), {31'b0, out_valid[i]}, 32'd0);
         check($sformatf("clr_underrun%0d", i),  {31'b0, underrun[i]},  32'd0);
         check($sformatf("clr_empty%0d", i),     {31'b0, in_ready[i]},  32'd1);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (out_valid[0]) begin
            if (q_a.size() == 0) check("a_spurious_valid", {31'b0, out_valid[0]}, 32'd0);
            else                 check("a_out_data", out_data_a, q_a.pop_front());
         end
         if (out_valid[1]) begin
            if (q_b.size() == 0) check("b_spurious_valid", {31'b0, out_valid[1]}, 32'd0);
            else                 check("b_out_data", out_data_b, q_b.pop_front());
         end
         if (out_valid[2]) begin
            if (q_c.size() == 0) check("c_spurious_valid", {31'b0, out_valid[2]}, 32'd0);
            else                 check("c_out_data", {24'b0, out_data_c}, q_c.pop_front());
         end
      end
   end

   initial begin
      vec_t vecs [$];

      // Impulse (a): 5 then zeros, held at 5.
      vecs.push_back('{dut: 0, valid: 1, data: 5, exp: 5});
      for (int i = 0; i < 7; i++) vecs.push_back('{dut: 0, valid: 0, data: 0, exp: 5});
      // Ramp (b): 1 then zeros -> 0,1,2,...
      vecs.push_back('{dut: 1, valid: 1, data: 1, exp: 0});
      for (int i = 1; i < 8; i++) vecs.push_back('{dut: 1, valid: 0, data: 0, exp: 32'(i)});
      // Wrap (c): 100 each period, 8-bit modulo.
      vecs.push_back('{dut: 2, valid: 1, data: 100, exp: 100});
      vecs.push_back('{dut: 2, valid: 0, data: 0,   exp: 100});
      vecs.push_back('{dut: 2, valid: 1, data: 100, exp: 32'hC8});
      vecs.push_back('{dut: 2, valid: 0, data: 0,   exp: 32'hC8});
      vecs.push_back('{dut: 2, valid: 1, data: 100, exp: 44});
      vecs.push_back('{dut: 2, valid: 0, data: 0,   exp: 44});
      vecs.push_back('{dut: 2, valid: 1, data: 100, exp: 144});
      vecs.push_back('{dut: 2, valid: 0, data: 0,   exp: 144});

      // Reset state.
      idle();
      rst = 1'b0;
      #2;
      check("rst_out_a", out_data_a, 32'd0);
      check("rst_out_b", out_data_b, 32'd0);
      check("rst_out_c", {24'b0, out_data_c}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_out_valid%0d", i), {31'b0, out_valid[i]}, 32'd0);
         check($sformatf("rst_underrun%0d", i),  {31'b0, underrun[i]},  32'd0);
         check($sformatf("rst_in_ready%0d", i),  {31'b0, in_ready[i]},  32'd0);
      end
      step();
      step();
      rst = 1'b1;
      #1;
      check("post_rst_in_ready", {31'b0, in_ready[0]}, 32'd1);

      // Table-driven impulse / ramp / wrap.
      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i].dut, vecs[i].valid, vecs[i].data, vecs[i].exp);
      end
      step();
      check("impulse_underrun", {31'b0, underrun[0]}, 32'd1);
      check("ramp_underrun",    {31'b0, underrun[1]}, 32'd1);
      check("wrap_no_underrun", {31'b0, underrun[2]}, 32'd0);

      // clr priority and flush.
      clr_pulse();
      check("clr_out_a", out_data_a, 32'd0);

      // Underrun: sample missing at phase 0 leaves the integrator unchanged.
      run_vec(0, 1, 7, 7);
      for (int i = 0; i < 3; i++) run_vec(0, 0, 0, 7);
      check("ur_before", {31'b0, underrun[0]}, 32'd0);
      run_vec(0, 0, 0, 7);
      check("ur_set", {31'b0, underrun[0]}, 32'd1);
      run_vec(0, 0, 0, 7);
      check("ur_sticky", {31'b0, underrun[0]}, 32'd1);
      step();
      clr_pulse();

      // Backpressure: full register holds off in_valid until the phase-0 tick.
      in_valid[0] = 1'b1;
      in_data[0]  = 11;
      #1;
      check("bp_empty_ready", {31'b0, in_ready[0]}, 32'd1);
      step();
      in_data[0] = 22;
      #1;
      check("bp_full_ready", {31'b0, in_ready[0]}, 32'd0);
      step();
      ena[0] = 1'b1;
      push_exp(0, 11);
      #1;
      check("bp_refill_ready", {31'b0, in_ready[0]}, 32'd1);
      step();
      for (int k = 1; k < 4; k++) begin
         push_exp(0, 11);
         #1;
         check($sformatf("bp_hold_ready%0d", k), {31'b0, in_ready[0]}, 32'd0);
         step();
      end
      push_exp(0, 33);
      #1;
      check("bp_refill2_ready", {31'b0, in_ready[0]}, 32'd1);
      step();
      ena[0]      = 1'b0;
      in_valid[0] = 1'b0;
      #1;
      check("bp_refilled", {31'b0, in_ready[0]}, 32'd0);
      check("bp_no_underrun", {31'b0, underrun[0]}, 32'd0);
      step();

      // Mid-period reset on (b): phase 2 with a held sample.
      clr_pulse();
      run_vec(1, 1, 3, 0);
      run_vec(1, 0, 0, 3);
      in_valid[1] = 1'b1;
      in_data[1]  = 9;
      step();
      in_valid[1] = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_out_a", out_data_a, 32'd0);
      check("mid_rst_out_b", out_data_b, 32'd0);
      check("mid_rst_ready_b", {31'b0, in_ready[1]}, 32'd0);
      check("mid_rst_valid_b", {31'b0, out_valid[1]}, 32'd0);
      step();
      step();
      rst = 1'b1;
      #1;
      check("mid_rst_empty_b", {31'b0, in_ready[1]}, 32'd1);
      run_vec(1, 0, 0, 0);
      check("mid_rst_phase0_underrun", {31'b0, underrun[1]}, 32'd1);
      run_vec(1, 1, 4, 0);
      run_vec(1, 0, 0, 0);
      run_vec(1, 0, 0, 0);
      run_vec(1, 0, 0, 0);
      run_vec(1, 0, 0, 4);
      step();
      step();

      check("q_a_drained", q_a.size(), 32'd0);
      check("q_b_drained", q_b.size(), 32'd0);
      check("q_c_drained", q_c.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
